// File: rtl/dval_pack_fifo.sv
// Packs PACK valid-only input words into one wide word and queues it in a DEPTH-entry FIFO.
// Optional macro DVAL_PACK_DROPCNT_EN adds a saturating 16-bit dropped-word counter o_drop.
module dval_pack_fifo #(
    parameter int IW    = 8,
    parameter int PACK  = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_dval,
    input  logic [IW-1:0]              i,
    input  logic                       i_flush,
    output logic                       o_dval,
    input  logic                       o_rdy,
    output logic [IW*PACK-1:0]         o,
    output logic                       o_part,
    output logic [$clog2(PACK+1)-1:0]  o_lanes,
`ifdef DVAL_PACK_DROPCNT_EN
    output logic [15:0]                o_drop,
`endif
    output logic                       ovf
);
    localparam int WW   = IW * PACK;
    localparam int LW   = $clog2(PACK + 1);
    localparam int CNTW = $clog2(PACK);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(PACK - 1);
    localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);

    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [WW-1:0]   pack_q, pack_d;
    logic [WW-1:0]   merged;
    logic [LW-1:0]   held;
    logic            full_push, flush_push, push;

    logic [WW-1:0]   mem_data [DEPTH];
    logic            mem_part [DEPTH];
    logic [LW-1:0]   mem_lanes[DEPTH];
    logic [PW-1:0]   wr_q, rd_q;
    logic [CW-1:0]   occ_q, occ_d;
    logic            empty, full, pop, wr_en, drop;
    logic            ovf_q;

    // Packing: merge the same-cycle word so a flush or completion sees it.
    always_comb begin
        merged = pack_q;
        for (int k = 0; k < PACK; k++) begin
            if (i_dval && cnt_q == CNTW'(k)) merged[k*IW +: IW] = i;
        end
        held       = LW'(cnt_q) + LW'(i_dval);
        full_push  = i_dval && (cnt_q == CNT_LAST);
        flush_push = i_flush && (held != '0) && !full_push;
        push       = full_push || flush_push;
        cnt_d      = cnt_q;
        pack_d     = pack_q;
        if (push) begin
            cnt_d  = '0;
            pack_d = '0;
        end else if (i_dval) begin
            cnt_d  = cnt_q + CNTW'(1);
            pack_d = merged;
        end
    end

    // FIFO control: a push into a full FIFO only lands if a pop frees the slot this cycle.
    always_comb begin
        empty = (occ_q == '0);
        full  = (occ_q == DEPTH_C);
        pop   = !empty && o_rdy;
        wr_en = push && (!full || pop);
        drop  = push && full && !pop;
        occ_d = occ_q;
        if (wr_en && !pop)      occ_d = occ_q + CW'(1);
        else if (!wr_en && pop) occ_d = occ_q - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            pack_q <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            occ_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pack_q <= pack_d;
            occ_q  <= occ_d;
            if (wr_en) wr_q <= wr_q + PW'(1);
            if (pop)   rd_q <= rd_q + PW'(1);
            if (drop)  ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_data[wr_q]  <= merged;
            mem_part[wr_q]  <= flush_push;
            mem_lanes[wr_q] <= held;
        end
    end

`ifdef DVAL_PACK_DROPCNT_EN
    logic [15:0] drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= '0;
        end else if (drop && drop_q != 16'hFFFF) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign o_drop = drop_q;
`endif

    // Head fields are forced to zero while empty so stale entries never leak out.
    assign o_dval  = !empty;
    assign o       = empty ? '0 : mem_data[rd_q];
    assign o_part  = empty ? 1'b0 : mem_part[rd_q];
    assign o_lanes = empty ? '0 : mem_lanes[rd_q];
    assign ovf     = ovf_q;
endmodule
